// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low {a,b,c,d,e,f,g,dp} bit layout
// and the hex glyph table used by every display block.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_A_BIT  = 7;
  localparam int SEG_B_BIT  = 6;
  localparam int SEG_C_BIT  = 5;
  localparam int SEG_D_BIT  = 4;
  localparam int SEG_E_BIT  = 3;
  localparam int SEG_F_BIT  = 2;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

  // Returns the glyph with the decimal point dark; callers overwrite bit 0.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    logic [7:0] pat;
    pat = SEG_OFF;
    case (nibble)
      4'h0: pat = 8'b0000_0011;
      4'h1: pat = 8'b1001_1111;
      4'h2: pat = 8'b0010_0101;
      4'h3: pat = 8'b0000_1101;
      4'h4: pat = 8'b1001_1001;
      4'h5: pat = 8'b0100_1001;
      4'h6: pat = 8'b0100_0001;
      4'h7: pat = 8'b0001_1111;
      4'h8: pat = 8'b0000_0001;
      4'h9: pat = 8'b0000_1001;
      4'hA: pat = 8'b0001_0001;
      4'hB: pat = 8'b1100_0001;
      4'hC: pat = 8'b0110_0011;
      4'hD: pat = 8'b1000_0101;
      4'hE: pat = 8'b0110_0001;
      4'hF: pat = 8'b0111_0001;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder, shared by the display blocks so the
// glyph table lives in exactly one place.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: double-buffered digit data, anti-ghost
// blanking at the start of each slot, leading-zero blanking and PWM dimming.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter  int DIGITS       = 8,
  parameter  int TICK_DIV     = 2048,
  parameter  int BLANK_CYCLES = 16,
  localparam int IDX_W        = $clog2(DIGITS)
) (
  input  logic                  clk_100M,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lzb,
  input  logic [3:0]            bright,
  input  logic                  load,
  output logic [IDX_W:0]        sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int               CYC_W     = $clog2(TICK_DIV);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TICK_DIV - 1);
  localparam logic [CYC_W-1:0] BLANK_END = CYC_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] SLOT_LAST = IDX_W'(DIGITS - 1);

  localparam logic PH_BLANK = 1'b0;
  localparam logic PH_SHOW  = 1'b1;
  localparam logic PH_RESET = (BLANK_CYCLES > 0) ? PH_BLANK : PH_SHOW;

  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [IDX_W-1:0]    slot_q, slot_d;
  logic                phase_q, phase_d;
  logic                cyc_wrap, boundary;

  logic [4*DIGITS-1:0] active_data_q, shadow_data_q;
  logic [DIGITS-1:0]   active_dp_q, shadow_dp_q;
  logic [DIGITS-1:0]   active_en_q, shadow_en_q;
  logic                pending_q;

  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   zero_prefix;
  logic [3:0]          cur_nib;
  logic [7:0]          digit_pat;
  logic                lz_blank, pwm_on, show;

  logic [7:0]          seg_q, seg_d;
  logic [IDX_W:0]      sel_q, sel_d;
  logic                frame_done_q;

  // NOTE: every always_comb target gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cyc_wrap = (cyc_q == CYC_LAST);
    boundary = cyc_wrap && (slot_q == SLOT_LAST);
    cyc_d    = cyc_wrap ? '0 : cyc_q + 1'b1;
    slot_d   = slot_q;
    if (cyc_wrap) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
    phase_d  = (cyc_d < BLANK_END) ? PH_BLANK : PH_SHOW;
  end

  // NOTE: sequential state uses non-blocking assignment only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      cyc_q   <= '0;
      slot_q  <= '0;
      phase_q <= PH_RESET;
    end else begin
      cyc_q   <= cyc_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
    end
  end

  // NOTE: the digit buffers are reset on purpose: a reset must blank the
  // display and drop any pending load rather than replay stale contents.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      active_data_q <= '0;
      active_dp_q   <= '0;
      active_en_q   <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_en_q   <= '0;
      pending_q     <= 1'b0;
    end else if (load) begin
      shadow_data_q <= data;
      shadow_dp_q   <= dp;
      shadow_en_q   <= digit_en;
      if (boundary) begin
        active_data_q <= data;
        active_dp_q   <= dp;
        active_en_q   <= digit_en;
        pending_q     <= 1'b0;
      end else begin
        pending_q     <= 1'b1;
      end
    end else if (boundary && pending_q) begin
      active_data_q <= shadow_data_q;
      active_dp_q   <= shadow_dp_q;
      active_en_q   <= shadow_en_q;
      pending_q     <= 1'b0;
    end
  end

  // Slot 0 is the most significant nibble; zero_prefix[i] means slots 0..i are all zero.
  always_comb begin
    logic run;
    run = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib[i]         = active_data_q[4*(DIGITS-i)-1 -: 4];
      run            = run && (nib[i] == 4'h0);
      zero_prefix[i] = run;
    end
  end

  assign cur_nib  = nib[slot_q];
  assign lz_blank = lzb && (slot_q != SLOT_LAST) && zero_prefix[slot_q];
  assign pwm_on   = (cyc_q[3:0] <= bright);
  assign show     = (phase_q == PH_SHOW);

  seg_hex_decode u_hex_decode (
    .nibble_i (cur_nib),
    .seg_o    (digit_pat)
  );

  always_comb begin
    seg_d = SEG_OFF;
    if (show && enable && active_en_q[slot_q] && pwm_on) begin
      seg_d             = lz_blank ? SEG_OFF : digit_pat;
      seg_d[SEG_DP_BIT] = ~active_dp_q[slot_q];
    end
    sel_d = {enable && show, slot_q};
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      seg_q        <= SEG_OFF;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= boundary;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule
